// File: rtl/uart_hex_tx_if.sv
// Value/valid/ready handshake between a producer and the hex-dump transmitter.
interface uart_hex_tx_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] value;
  logic                  valid;
  logic                  ready;

  modport master (output value, output valid, input ready);
  modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/uart_hex_tx.sv
// UART hex-dump transmitter: queues values in a small FIFO and prints each one
// as uppercase ASCII hex (MSB nibble first) followed by CR LF or a space.
module uart_hex_tx #(
  parameter int DATA_WIDTH   = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int LINE_END     = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  uart_hex_tx_if.slave                  host,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx
);

  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int NCHARS  = NIBBLES + ((LINE_END != 0) ? 2 : 1);
  localparam int CW      = $clog2(NCHARS);
  localparam int BW      = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE    = BW'(1);
  localparam logic [AW:0]   PTR_ONE     = (AW + 1)'(1);
  localparam logic [CW-1:0] CHAR_ONE    = CW'(1);
  localparam logic [CW-1:0] LAST_CHAR   = CW'(NCHARS - 1);
  localparam logic [CW-1:0] FIRST_TERM  = CW'(NIBBLES);
  localparam logic [7:0]    TERM_CODE   = (LINE_END != 0) ? 8'h0D : 8'h20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_reg, state_next;
  logic [AW:0]           wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         baud_reg;
  logic [2:0]            bit_reg;
  logic [CW-1:0]         char_reg;
  logic                  tx_reg, tx_next;
  logic                  busy_reg, busy_next;
  logic                  overflow_reg;

  logic                  full, empty, push, pop;
  logic                  bit_done, last_bit, last_char, next_char;
  logic [7:0]            char_code;
  logic [7:0]            hex_ascii [16];

  // Nibble-to-ASCII table: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  for (genvar gi = 0; gi < 16; gi++) begin : g_hex
    localparam logic [7:0] CODE = (gi < 10) ? 8'(48 + gi) : 8'(55 + gi);
    assign hex_ascii[gi] = CODE;
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign push  = host.valid && !full;

  assign host.ready = !full;
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign overflow   = overflow_reg;
  assign busy       = busy_reg;
  assign tx         = tx_reg;

  assign bit_done  = (baud_reg == '0);
  assign last_bit  = (bit_reg == 3'd7);
  assign last_char = (char_reg == LAST_CHAR);
  assign next_char = (state_reg == STOP) && bit_done && !last_char;

  // FIFO storage: write-only array, read through the registered pop into shift_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= host.value;
    end
  end

  // FIFO pointers advance on accepted pushes and on FSM pops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // FSM next-state logic; a pop happens when leaving IDLE or after the last character.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        if (bit_done && last_bit) state_next = STOP;
      end
      STOP: begin
        if (bit_done) begin
          if (!last_char) begin
            state_next = START;
          end else if (!empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Character being sent: hex digit from the top nibble, then the terminator(s).
  always_comb begin
    char_code = 8'h0A;
    if (char_reg < FIRST_TERM) begin
      char_code = hex_ascii[shift_reg[DATA_WIDTH-1 -: 4]];
    end else if (char_reg == FIRST_TERM) begin
      char_code = TERM_CODE;
    end
  end

  // FSM outputs; busy spans from the pop until the registered stop bit has finished.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_reg != IDLE) || (state_next != IDLE);
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = char_code[bit_reg];
      default: tx_next = 1'b1;
    endcase
  end

  // Registered outputs so tx, busy and overflow are glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      overflow_reg <= host.valid && full;
    end
  end

  // Baud counter and bit index: every bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_reg <= BAUD_RELOAD;
      bit_reg  <= 3'd0;
    end else begin
      if ((state_reg == IDLE) || bit_done) baud_reg <= BAUD_RELOAD;
      else                                 baud_reg <= baud_reg - BAUD_ONE;

      if (state_reg == DATA) begin
        if (bit_done) bit_reg <= last_bit ? 3'd0 : bit_reg + 3'd1;
      end else begin
        bit_reg <= 3'd0;
      end
    end
  end

  // Value shift register and character counter: load on pop, step per character.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      char_reg  <= '0;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr_reg[AW-1:0]];
      char_reg  <= '0;
    end else if (next_char) begin
      shift_reg <= shift_reg << 4;
      char_reg  <= char_reg + CHAR_ONE;
    end
  end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed bench: two transmitters (32-bit CR/LF and 8-bit space-terminated),
// tx lines logged every cycle and decoded at mid-bit.
module tb_uart_hex_tx;

  localparam int CPB  = 4;
  localparam int LINE = 10 * 10 * CPB;
  localparam int LOGN = 16384;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_hex_tx_if #(.DATA_WIDTH(32)) bus_a ();
  uart_hex_tx_if #(.DATA_WIDTH(8))  bus_b ();

  logic       ovf_a, busy_a, tx_a;
  logic [2:0] lvl_a;
  logic       ovf_b, busy_b, tx_b;
  logic [2:0] lvl_b;

  uart_hex_tx #(.DATA_WIDTH(32), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .LINE_END(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .host(bus_a), .overflow(ovf_a),
    .fifo_level(lvl_a), .busy(busy_a), .tx(tx_a)
  );

  uart_hex_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .LINE_END(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .host(bus_b), .overflow(ovf_b),
    .fifo_level(lvl_b), .busy(busy_b), .tx(tx_b)
  );

  int   cyc = 0;
  logic log_a  [LOGN];
  logic log_b  [LOGN];
  logic blog_a [LOGN];

  always @(posedge clk) cyc <= cyc + 1;

  // log[E] holds the line value in the cycle following posedge number E
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_a[cyc]  = tx_a;
      log_b[cyc]  = tx_b;
      blog_a[cyc] = busy_a;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic logic sample(input bit sel, input int pos);
    if (pos < 0 || pos >= LOGN) return 1'bx;
    return sel ? log_b[pos] : log_a[pos];
  endfunction

  // Decode one frame whose start bit begins at log index idx; raw[9] is the start bit.
  task automatic rx_char(input bit sel, input int idx, output logic [7:0] ch, output logic [9:0] raw);
    for (int k = 0; k < 10; k++) raw[9-k] = sample(sel, idx + k * CPB + CPB / 2);
    for (int i = 0; i < 8; i++) ch[i] = raw[8-i];
  endtask

  function automatic int idle_errs(input bit sel, input int from, input int to);
    int n = 0;
    for (int i = from; i <= to; i++) if (sample(sel, i) !== 1'b1) n++;
    return n;
  endfunction

  // Decode one 32-bit line (8 digits + CR LF) starting at idx.
  task automatic check_line(input string tag, input int idx, input logic [63:0] exp_digits);
    logic [63:0] digits;
    logic [15:0] term;
    logic [7:0]  ch;
    logic [9:0]  raw;
    int          bad;
    digits = '0;
    term   = '0;
    bad    = 0;
    for (int k = 0; k < 10; k++) begin
      rx_char(1'b0, idx + k * 10 * CPB, ch, raw);
      if (raw[9] !== 1'b0 || raw[0] !== 1'b1) bad++;
      if (k < 8) digits = {digits[55:0], ch};
      else       term   = {term[7:0], ch};
    end
    check($sformatf("%s_digits", tag), digits, exp_digits);
    check($sformatf("%s_term", tag), 64'(term), 64'h0D0A);
    check($sformatf("%s_frame", tag), 64'(bad), 64'd0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  logic [31:0] vals5 [5];
  logic [63:0] exp5  [5];

  initial begin
    int          p;
    logic [7:0]  ch;
    logic [9:0]  raw;
    logic [23:0] packed_b;
    int          bad_b;

    vals5 = '{32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF, 32'h0123ABCD, 32'h00000009};
    exp5  = '{64'h4646464646464646, 64'h3030303030303030, 64'h4445414442454546,
              64'h3031323341424344, 64'h3030303030303039};

    bus_a.valid = 1'b0; bus_a.value = '0;
    bus_b.valid = 1'b0; bus_b.value = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_tx", 64'(tx_a), 64'd1);
    check("rst_ready", 64'(bus_a.ready), 64'd1);
    check("rst_overflow", 64'(ovf_a), 64'd0);
    check("rst_level", 64'(lvl_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single value on both transmitters
    p = cyc + 1;
    bus_a.value = 32'h12345678; bus_a.valid = 1'b1;
    bus_b.value = 8'hAF;        bus_b.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0; bus_b.valid = 1'b0;
    check("t1_level_after_push", 64'(lvl_a), 64'd1);
    wait_until(p + LINE + 10);
    check("t1_idle_before_start", 64'(log_a[p+1]), 64'd1);
    check("t1_start_fall", 64'(log_a[p+2]), 64'd0);
    rx_char(1'b0, p + 2, ch, raw);
    check("t1_first_frame", 64'(raw), 64'b0100011001);
    check_line("t1", p + 2, 64'h3132333435363738);
    check("t1_busy_last_stop", 64'(blog_a[p+LINE+1]), 64'd1);
    check("t1_busy_drop", 64'(blog_a[p+LINE+2]), 64'd0);

    packed_b = '0;
    bad_b    = 0;
    for (int k = 0; k < 3; k++) begin
      rx_char(1'b1, p + 2 + k * 10 * CPB, ch, raw);
      if (raw[9] !== 1'b0 || raw[0] !== 1'b1) bad_b++;
      packed_b = {packed_b[15:0], ch};
    end
    check("t2_chars", 64'(packed_b), 64'h414620);
    check("t2_frame", 64'(bad_b), 64'd0);
    check("t2_idle_after", 64'(idle_errs(1'b1, p + 2 + 30 * CPB, p + LINE + 9)), 64'd0);

    // six-cycle burst into a depth-4 FIFO while idle
    p = cyc + 1;
    for (int k = 1; k <= 6; k++) begin
      bus_a.value = 32'(k);
      bus_a.valid = 1'b1;
      if (k == 5) check("t3_ready_before_5th", 64'(bus_a.ready), 64'd1);
      if (k == 6) begin
        check("t3_ready_before_6th", 64'(bus_a.ready), 64'd0);
        check("t3_no_ovf_yet", 64'(ovf_a), 64'd0);
      end
      @(negedge clk);
    end
    bus_a.valid = 1'b0;
    check("t3_ovf_pulse", 64'(ovf_a), 64'd1);
    check("t3_level_full", 64'(lvl_a), 64'd4);
    @(negedge clk);
    check("t3_ovf_cleared", 64'(ovf_a), 64'd0);
    wait_until(p + 5 * LINE + 10);
    for (int v = 1; v <= 5; v++)
      check_line($sformatf("t3_v%0d", v), p + 2 + LINE * (v - 1), 64'h3030303030303030 + 64'(v));
    check("t3_idle_after", 64'(idle_errs(1'b0, p + 2 + 5 * LINE, p + 5 * LINE + 9)), 64'd0);
    check("t3_level_empty", 64'(lvl_a), 64'd0);
    check("t3_busy_clear", 64'(busy_a), 64'd0);

    // reset in the middle of the third character's data bits
    p = cyc + 1;
    bus_a.value = 32'h12345678; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.value = 32'hCAFEF00D;
    @(negedge clk);
    bus_a.valid = 1'b0;
    wait_until(p + 95);
    check("t4_tx_low_before_reset", 64'(tx_a), 64'd0);
    check("t4_level_before_reset", 64'(lvl_a), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t4_tx_at_reset", 64'(tx_a), 64'd1);
    check("t4_busy_at_reset", 64'(busy_a), 64'd0);
    check("t4_level_at_reset", 64'(lvl_a), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    p = cyc + 1;
    bus_a.value = 32'h0; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0;
    wait_until(p + LINE + 10);
    check("t4_start_fall", 64'(log_a[p+2]), 64'd0);
    check_line("t4", p + 2, 64'h3030303030303030);
    check("t4_idle_after", 64'(idle_errs(1'b0, p + 2 + LINE, p + LINE + 9)), 64'd0);

    // full FIFO with a refused push on the pop edge; also FFFFFFFF then 00000000
    p = cyc + 1;
    for (int k = 0; k < 5; k++) begin
      bus_a.value = vals5[k];
      bus_a.valid = 1'b1;
      @(negedge clk);
    end
    bus_a.valid = 1'b0;
    check("t5_level_full", 64'(lvl_a), 64'd4);
    wait_until(p + LINE);
    check("t5_ready_low", 64'(bus_a.ready), 64'd0);
    bus_a.value = 32'h55555555; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0;
    check("t5_level_after_pop", 64'(lvl_a), 64'd3);
    check("t5_ovf_on_pop_edge", 64'(ovf_a), 64'd1);
    wait_until(p + 5 * LINE + 10);
    for (int v = 0; v < 5; v++)
      check_line($sformatf("t5_v%0d", v), p + 2 + LINE * v, exp5[v]);
    check("t5_idle_after", 64'(idle_errs(1'b0, p + 2 + 5 * LINE, p + 5 * LINE + 9)), 64'd0);
    check("t5_level_empty", 64'(lvl_a), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
